// File: rtl/act_ctrl_pkg.sv
// Shared types and defaults for the activation ping-pong controller.
package act_ctrl_pkg;

  localparam int ACT_ADR_W = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } act_state_e;

  typedef logic bank_idx_t;

endpackage

// File: rtl/act_len_cnt.sv
// Length-bounded word counter: clear, increment on accept, and cnt==len flags
// for both the current and the next count.
module act_len_cnt
  import act_ctrl_pkg::*;
#(
  parameter int AW = ACT_ADR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  input  logic [AW:0]   len,
  output logic [AW-1:0] addr,
  output logic          done,
  output logic          done_next
);

  localparam logic [AW:0] ONE = 1;

  logic [AW:0] cnt_reg;
  logic [AW:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (inc) begin
      cnt_next = cnt_reg + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign addr      = cnt_reg[AW-1:0];
  assign done      = (cnt_reg == len);
  assign done_next = (cnt_next == len);

endmodule

// File: rtl/act_pingpong_ctrl.sv
// Streams one layer's inputs out of src_bank and engine results into the other
// bank of act_unimem, swapping roles per layer. ACT_PP_HOST_LOAD_EN adds host preload ports.
module act_pingpong_ctrl
  import act_ctrl_pkg::*;
#(
  parameter int ACTMEMADRWID = ACT_ADR_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    layer_start,
  input  logic [ACTMEMADRWID:0]   rd_len,
  input  logic [ACTMEMADRWID:0]   wr_len,
  input  logic                    rd_req,
  output logic                    rd_rdy,
  output logic                    rd_vld,
  input  logic                    wr_vld,
`ifdef ACT_PP_HOST_LOAD_EN
  input  logic                    host_wen,
  input  logic                    host_bank,
  input  logic [ACTMEMADRWID-1:0] host_addr,
`endif
  output logic                    busy,
  output logic                    layer_done,
  output logic                    src_bank,
  output logic                    wr_ovf,
  output logic                    ractmem0ena,
  output logic                    ractmem1ena,
  output logic [ACTMEMADRWID-1:0] ractmem0addr,
  output logic [ACTMEMADRWID-1:0] ractmem1addr,
  output logic                    wactmem0ena,
  output logic                    wactmem1ena,
  output logic [ACTMEMADRWID-1:0] wactmem0addr,
  output logic [ACTMEMADRWID-1:0] wactmem1addr
);

  act_state_e state_reg, state_next;
  bank_idx_t  src_bank_reg;

  logic [ACTMEMADRWID:0]   rd_len_reg, wr_len_reg;
  logic [ACTMEMADRWID-1:0] rd_cnt_addr, wr_cnt_addr;
  logic rd_done, rd_done_next, wr_done, wr_done_next;
  logic start_acc, rd_rdy_c, rd_acc, wr_acc, rd_on;
  logic rd_vld_reg, wr_ovf_reg;

  logic                    host_sel;
  bank_idx_t               host_bank_sel;
  logic [ACTMEMADRWID-1:0] host_adr;

  logic [1:0]                        rd_ena, wr_ena;
  logic [1:0][ACTMEMADRWID-1:0]      rd_addr, wr_addr;

  act_len_cnt #(.AW(ACTMEMADRWID)) u_rd_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (start_acc),
    .inc       (rd_acc),
    .len       (rd_len_reg),
    .addr      (rd_cnt_addr),
    .done      (rd_done),
    .done_next (rd_done_next)
  );

  act_len_cnt #(.AW(ACTMEMADRWID)) u_wr_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (start_acc),
    .inc       (wr_acc),
    .len       (wr_len_reg),
    .addr      (wr_cnt_addr),
    .done      (wr_done),
    .done_next (wr_done_next)
  );

  // RUN ends on the cycle that accepts the last word, so the read-data return
  // cycle lands in DRAIN and layer_done follows two cycles after that accept.
  always_comb begin
    state_next = state_reg;
    start_acc  = (state_reg == IDLE) && layer_start;
    rd_rdy_c   = (state_reg == RUN) && !rd_done;
    rd_acc     = rd_req && rd_rdy_c;
    wr_acc     = (state_reg == RUN) && wr_vld && !wr_done;
    rd_on      = ((state_reg == RUN) || (state_reg == DRAIN)) && (rd_len_reg != '0);
    case (state_reg)
      IDLE:    if (layer_start) state_next = RUN;
      RUN:     if (rd_done_next && wr_done_next) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_len_reg   <= '0;
      wr_len_reg   <= '0;
      src_bank_reg <= 1'b0;
      rd_vld_reg   <= 1'b0;
      wr_ovf_reg   <= 1'b0;
    end else begin
      rd_vld_reg <= rd_acc;
      if (start_acc) begin
        rd_len_reg <= rd_len;
        wr_len_reg <= wr_len;
        wr_ovf_reg <= 1'b0;
      end else if ((state_reg == RUN) && wr_vld && wr_done) begin
        wr_ovf_reg <= 1'b1;
      end
      if (state_reg == DONE) begin
        src_bank_reg <= ~src_bank_reg;
      end
    end
  end

`ifdef ACT_PP_HOST_LOAD_EN
  assign host_sel      = (state_reg == IDLE) && host_wen;
  assign host_bank_sel = host_bank;
  assign host_adr      = host_addr;
`else
  assign host_sel      = 1'b0;
  assign host_bank_sel = 1'b0;
  assign host_adr      = '0;
`endif

  // Engine writes only occur in RUN and host writes only in IDLE, so they never collide.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic eng_hit, host_hit;
    assign rd_ena[gi]  = rd_on && (src_bank_reg == 1'(gi));
    assign rd_addr[gi] = rd_ena[gi] ? rd_cnt_addr : '0;
    assign eng_hit     = wr_acc && (src_bank_reg != 1'(gi));
    assign host_hit    = host_sel && (host_bank_sel == 1'(gi));
    assign wr_ena[gi]  = eng_hit || host_hit;
    assign wr_addr[gi] = eng_hit ? wr_cnt_addr : (host_hit ? host_adr : '0);
  end

  assign rd_rdy       = rd_rdy_c;
  assign rd_vld       = rd_vld_reg;
  assign busy         = (state_reg != IDLE);
  assign layer_done   = (state_reg == DONE);
  assign src_bank     = src_bank_reg;
  assign wr_ovf       = wr_ovf_reg;
  assign ractmem0ena  = rd_ena[0];
  assign ractmem1ena  = rd_ena[1];
  assign ractmem0addr = rd_addr[0];
  assign ractmem1addr = rd_addr[1];
  assign wactmem0ena  = wr_ena[0];
  assign wactmem1ena  = wr_ena[1];
  assign wactmem0addr = wr_addr[0];
  assign wactmem1addr = wr_addr[1];

endmodule

// File: tb/tb_act_pingpong_ctrl.sv
// Self-checking bench for act_pingpong_ctrl: layer-level behavioural model checked
// every cycle, plus directed layers with hand-computed expectations.
module tb_act_pingpong_ctrl;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          layer_start;
  logic [AW:0]   rd_len, wr_len;
  logic          rd_req, rd_rdy, rd_vld, wr_vld;
  logic          busy, layer_done, src_bank, wr_ovf;
  logic          ractmem0ena, ractmem1ena, wactmem0ena, wactmem1ena;
  logic [AW-1:0] ractmem0addr, ractmem1addr, wactmem0addr, wactmem1addr;
`ifdef ACT_PP_HOST_LOAD_EN
  logic          host_wen, host_bank;
  logic [AW-1:0] host_addr;
`endif

  always #5 clk = ~clk;

  act_pingpong_ctrl #(.ACTMEMADRWID(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .layer_start  (layer_start),
    .rd_len       (rd_len),
    .wr_len       (wr_len),
    .rd_req       (rd_req),
    .rd_rdy       (rd_rdy),
    .rd_vld       (rd_vld),
    .wr_vld       (wr_vld),
`ifdef ACT_PP_HOST_LOAD_EN
    .host_wen     (host_wen),
    .host_bank    (host_bank),
    .host_addr    (host_addr),
`endif
    .busy         (busy),
    .layer_done   (layer_done),
    .src_bank     (src_bank),
    .wr_ovf       (wr_ovf),
    .ractmem0ena  (ractmem0ena),
    .ractmem1ena  (ractmem1ena),
    .ractmem0addr (ractmem0addr),
    .ractmem1addr (ractmem1addr),
    .wactmem0ena  (wactmem0ena),
    .wactmem1ena  (wactmem1ena),
    .wactmem0addr (wactmem0addr),
    .wactmem1addr (wactmem1addr)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_no  = 0;

  // Layer-level model: lengths, words moved so far, and post-completion tail cycles.
  bit m_busy, m_work, m_bank, m_ovf, m_vld;
  int m_tail, m_rc, m_wc, m_rl, m_wl;

  int rd_log[$], wr_log[$], vld_log[$], done_log[$];
  int last_acc, rd_ena_cnt, wr_ena_cnt, start_cycle;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_no);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_work = 0; m_bank = 0; m_ovf = 0; m_vld = 0;
    m_tail = 0; m_rc = 0; m_wc = 0; m_rl = 0; m_wl = 0;
  endtask

  task automatic clear_logs();
    rd_log.delete(); wr_log.delete(); vld_log.delete(); done_log.delete();
    last_acc = -1; rd_ena_cnt = 0; wr_ena_cnt = 0;
  endtask

  // Inputs are already driven; check this cycle's outputs, then advance the model over the edge.
  task automatic step();
    bit racc, wacc, ovf_hit, rd_phase;
    bit e_rena[2], e_wena[2];
    int e_radr[2], e_wadr[2];
    #2;
    rd_phase = (m_work || m_tail == 1) && m_rl != 0;
    racc     = m_work && (m_rc < m_rl) && rd_req;
    wacc     = m_work && wr_vld && (m_wc < m_wl);
    ovf_hit  = m_work && wr_vld && !(m_wc < m_wl);
    for (int b = 0; b < 2; b++) begin
      e_rena[b] = rd_phase && (int'(m_bank) == b);
      e_radr[b] = e_rena[b] ? m_rc : 0;
      e_wena[b] = wacc && (int'(m_bank) != b);
      e_wadr[b] = e_wena[b] ? m_wc : 0;
    end
`ifdef ACT_PP_HOST_LOAD_EN
    if (!m_busy && host_wen) begin
      e_wena[int'(host_bank)] = 1;
      e_wadr[int'(host_bank)] = int'(host_addr);
    end
`endif
    chk("busy", busy, m_busy);
    chk("rd_rdy", rd_rdy, m_work && (m_rc < m_rl));
    chk("rd_vld", rd_vld, m_vld);
    chk("layer_done", layer_done, m_tail == 2);
    chk("src_bank", src_bank, m_bank);
    chk("wr_ovf", wr_ovf, m_ovf);
    chk("ractmem0ena", ractmem0ena, e_rena[0]);
    chk("ractmem1ena", ractmem1ena, e_rena[1]);
    chk("ractmem0addr", ractmem0addr, e_radr[0]);
    chk("ractmem1addr", ractmem1addr, e_radr[1]);
    chk("wactmem0ena", wactmem0ena, e_wena[0]);
    chk("wactmem1ena", wactmem1ena, e_wena[1]);
    chk("wactmem0addr", wactmem0addr, e_wadr[0]);
    chk("wactmem1addr", wactmem1addr, e_wadr[1]);

    if (rd_req && rd_rdy) begin
      rd_log.push_back(src_bank ? int'(ractmem1addr) : int'(ractmem0addr));
      last_acc = cyc_no;
    end
    if (wacc) wr_log.push_back(m_bank ? int'(wactmem0addr) : int'(wactmem1addr));
    if (rd_vld) vld_log.push_back(cyc_no - start_cycle);
    if (layer_done) done_log.push_back(cyc_no - start_cycle);
    rd_ena_cnt += int'(ractmem0ena) + int'(ractmem1ena);
    wr_ena_cnt += int'(wactmem0ena) + int'(wactmem1ena);

    if (!m_busy) begin
      if (layer_start) begin
        m_busy = 1; m_work = 1; m_rl = int'(rd_len); m_wl = int'(wr_len);
        m_rc = 0; m_wc = 0; m_ovf = 0;
      end
    end else if (m_work) begin
      if (racc) m_rc++;
      if (wacc) m_wc++;
      if (ovf_hit) m_ovf = 1;
      if (m_rc == m_rl && m_wc == m_wl) begin
        m_work = 0; m_tail = 1;
      end
    end else if (m_tail == 1) begin
      m_tail = 2;
    end else begin
      m_tail = 0; m_busy = 0; m_bank = !m_bank;
    end
    m_vld = racc;
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  // pat 0: rd/wr held high; 1: random; 2: rd_req 1,0,1,1,1..; 3: 3 wr pulses; 4: idle + late start.
  task automatic run_layer(input int rl, input int wl, input int pat, input int maxc);
    clear_logs();
    start_cycle = cyc_no;
    layer_start = 1; rd_len = (AW+1)'(rl); wr_len = (AW+1)'(wl);
    step();
    layer_start = 0;
    for (int i = 0; i < maxc && m_busy; i++) begin
      case (pat)
        0: begin rd_req = 1; wr_vld = 1; end
        1: begin
          rd_req = 1'($urandom_range(0, 3) != 0);
          wr_vld = 1'($urandom_range(0, 2) != 0);
          layer_start = 1'($urandom_range(0, 7) == 0);
        end
        2: begin rd_req = (i != 1); wr_vld = 1; end
        3: begin rd_req = 1; wr_vld = (i < 3); end
        default: begin rd_req = 0; wr_vld = 0; layer_start = (i == 0); end
      endcase
`ifdef ACT_PP_HOST_LOAD_EN
      host_wen = 1'($urandom_range(0, 1)); host_bank = 1'($urandom_range(0, 1));
      host_addr = AW'($urandom_range(0, 1023));
`endif
      step();
    end
    layer_start = 0; rd_req = 0; wr_vld = 0;
    chk("layer_ends_idle", busy, 0);
    $display("[TB] layer rd_len=%0d wr_len=%0d reads=%0d writes=%0d done_pulses=%0d src_bank=%0d",
             rl, wl, rd_log.size(), wr_log.size(), done_log.size(), src_bank);
  endtask

  task automatic chk_seq(input string name, input int q[$], input int n);
    chk({name, "_count"}, q.size(), n);
    foreach (q[i]) chk(name, q[i], i);
  endtask

  initial begin
    rst_n = 0; layer_start = 0; rd_len = '0; wr_len = '0; rd_req = 0; wr_vld = 0;
`ifdef ACT_PP_HOST_LOAD_EN
    host_wen = 0; host_bank = 0; host_addr = '0;
`endif
    model_reset();
    clear_logs();
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_src_bank", src_bank, 0);
    chk("rst_outs", {rd_rdy, rd_vld, layer_done, wr_ovf, ractmem0ena, ractmem1ena,
                     wactmem0ena, wactmem1ena}, 0);
    chk("rst_addrs", {ractmem0addr, ractmem1addr, wactmem0addr, wactmem1addr}, 0);
    @(posedge clk); #1;
    rst_n = 1;
    step();

    // Layer 1: bank0 -> bank1, four words each way.
    run_layer(4, 4, 0, 40);
    chk_seq("l1_rd_addr", rd_log, 4);
    chk_seq("l1_wr_addr", wr_log, 4);
    chk("l1_done_pulses", done_log.size(), 1);
    chk("l1_done_after_last_acc", start_cycle + done_log[0] - last_acc, 2);
    chk("l1_rd_ena_cycles", rd_ena_cnt, 5);
    chk("l1_src_bank", src_bank, 1);

    // Layer 2: bank1 -> bank0, read enable held through DRAIN.
    run_layer(3, 2, 0, 40);
    chk_seq("l2_rd_addr", rd_log, 3);
    chk_seq("l2_wr_addr", wr_log, 2);
    chk("l2_rd_ena_cycles", rd_ena_cnt, 4);
    chk("l2_src_bank", src_bank, 0);

    // Gapped reads: rd_vld trails each accept by one cycle.
    run_layer(4, 0, 2, 40);
    chk_seq("l3_rd_addr", rd_log, 4);
    chk("l3_vld_count", vld_log.size(), 4);
    if (vld_log.size() == 4) begin
      chk("l3_vld0", vld_log[0], 2);
      chk("l3_vld1", vld_log[1], 4);
      chk("l3_vld2", vld_log[2], 5);
      chk("l3_vld3", vld_log[3], 6);
    end
    chk("l3_done_at", done_log.size() > 0 ? done_log[0] : -1, 7);

    // Overflowing write stream.
    run_layer(4, 2, 3, 40);
    chk("l4_wr_enables", wr_ena_cnt, 2);
    chk("l4_wr_ovf_after", wr_ovf, 1);

    // Empty layer, with a layer_start issued while busy.
    run_layer(0, 0, 4, 20);
    chk("l5_done_at", done_log.size() > 0 ? done_log[0] : -1, 3);
    chk("l5_done_pulses", done_log.size(), 1);
    chk("l5_no_enables", rd_ena_cnt + wr_ena_cnt, 0);
    chk("l5_ovf_cleared", wr_ovf, 0);
    step();

    for (int n = 0; n < 25; n++) begin
      run_layer($urandom_range(0, 12), $urandom_range(0, 12), 1, 200);
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        rd_req = 1'($urandom_range(0, 1)); wr_vld = 1'($urandom_range(0, 1));
        step();
      end
      rd_req = 0; wr_vld = 0;
    end

`ifdef ACT_PP_HOST_LOAD_EN
    host_wen = 1; host_bank = 1; host_addr = AW'(5);
    #2;
    chk("host_wena1", wactmem1ena, 1);
    chk("host_waddr1", wactmem1addr, 5);
    chk("host_wena0", wactmem0ena, 0);
    step();
    host_wen = 0; host_bank = 0; host_addr = '0;
`endif

    // Mid-layer reset with src_bank at 1.
    if (!m_bank) run_layer(0, 0, 0, 20);
    clear_logs();
    start_cycle = cyc_no;
    layer_start = 1; rd_len = 11'd8; wr_len = 11'd8;
    step();
    layer_start = 0; rd_req = 1; wr_vld = 1;
    for (int i = 0; i < 3; i++) step();
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_bank", src_bank, 1);
    #3;
    rst_n = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_src_bank", src_bank, 0);
    chk("arst_outs", {rd_rdy, rd_vld, layer_done, wr_ovf, ractmem0ena, ractmem1ena,
                      wactmem0ena, wactmem1ena}, 0);
    chk("arst_addrs", {ractmem0addr, ractmem1addr, wactmem0addr, wactmem1addr}, 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1; rd_req = 0; wr_vld = 0;
    for (int i = 0; i < 4; i++) step();
    chk("post_rst_no_done", done_log.size(), 0);
    run_layer(2, 2, 0, 40);
    chk_seq("post_rst_rd_addr", rd_log, 2);
    chk("post_rst_bank", src_bank, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc_no);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/act_pingpong_ctrl.md
# act_pingpong_ctrl

Sequencing controller for the two-bank activation memory (`act_unimem`). For each network layer it reads input activations from the current source bank toward the compute engine and directs the engine's results into the opposite bank. At layer end it swaps the bank roles, so the output of layer N becomes the input of layer N+1. It sits between the layer scheduler (start/done, lengths), the compute engine (read/write streams) and the enable/address ports of `act_unimem`.

## Interface
- ACTMEMADRWID, 10, activation memory address width
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- layer_start  in  1  single-cycle pulse that starts a layer; honoured only in IDLE
- rd_len  in  ACTMEMADRWID+1  number of words to read this layer; sampled on an accepted layer_start
- wr_len  in  ACTMEMADRWID+1  number of words to write this layer; sampled on an accepted layer_start
- rd_req  in  1  engine requests the next input word
- rd_rdy  out  1  read request will be accepted this cycle
- rd_vld  out  1  swumemdata holds the requested word this cycle
- wr_vld  in  1  engine presents a result word on wactmemdata this cycle
- busy  out  1  layer in progress (not IDLE)
- layer_done  out  1  single-cycle pulse when a layer completes
- src_bank  out  1  bank currently read (0/1)
- wr_ovf  out  1  sticky flag: a write arrived after wr_len was reached; cleared by layer_start
- ractmem0ena, ractmem1ena  out  1  read enables to act_unimem
- ractmem0addr, ractmem1addr  out  ACTMEMADRWID  read addresses
- wactmem0ena, wactmem1ena  out  1  write enables to act_unimem
- wactmem0addr, wactmem1addr  out  ACTMEMADRWID  write addresses

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on layer_start. This transition latches rd_len and wr_len, clears both counters and clears wr_ovf.
- RUN -> DRAIN when rd_cnt==rd_len and wr_cnt==wr_len. DRAIN -> DONE after one cycle. DONE -> IDLE after one cycle.
- In DONE: layer_done=1 and src_bank toggles.
- Read side, in RUN and DRAIN:
  - ractmem[src_bank]ena is held at 1 continuously. act_unimem selects its output using this enable, so the enable must stay high through the data-return cycle.
  - The read address for the src_bank port is rd_cnt.
  - rd_rdy = (state==RUN) && rd_cnt<rd_len.
  - An accepted read (rd_req && rd_rdy) increments rd_cnt at the next edge.
- Write side, in RUN only:
  - A write is accepted when wr_vld && wr_cnt<wr_len. In that case wactmem[~src_bank]ena=1 in the same cycle (combinational), the address is wr_cnt, and wr_cnt increments.
  - A write with wr_vld && wr_cnt==wr_len is dropped and sets wr_ovf.
- All enables for the other bank are 0. Read and write never target the same bank.
- rd_len=0: no reads occur. wr_len=0: no writes occur. rd_len=wr_len=0: RUN lasts exactly one cycle.
- Counters are ACTMEMADRWID+1 bits and compare against len; no wrap-around is possible. A len above 2^ACTMEMADRWID is out of range and its behaviour is unspecified.
- layer_start in any state other than IDLE is ignored.
- Simultaneous read and write in the same cycle are both accepted.

## Timing
- Read latency is 1: an accept in cycle t gives rd_vld=1 in t+1, with data on swumemdata in t+1. One word per cycle sustained.
- Write latency is 0: the enable and address are driven in the cycle wr_vld is presented.
- layer_done fires 2 cycles after the last counter completes (one DRAIN cycle, then DONE).
- Reset values: state IDLE; all enables 0; all addresses 0; rd_vld, rd_rdy, busy, layer_done, wr_ovf all 0; src_bank 0.
- Reset asserted mid-layer aborts the layer immediately. No layer_done is issued and the bank returns to 0.

## Configuration
- ACT_PP_HOST_LOAD_EN, when defined, adds three ports: host_wen in 1, host_bank in 1, host_addr in ACTMEMADRWID.
  - In IDLE, host_wen drives wactmem[host_bank]ena and its address with zero latency.
  - This lets the host preload the first layer's input.
  - host_wen outside IDLE is ignored.
- When the macro is undefined, these ports do not exist and write enables are driven only by the engine path.

## Structure
- Package act_ctrl_pkg holds:
  - the state enum (IDLE/RUN/DRAIN/DONE);
  - the default ACTMEMADRWID;
  - a bank-index typedef.
- One sub-module, act_len_cnt: clear, increment-on-accept, and a done flag (cnt==len). It is instantiated twice, once for the read counter and once for the write counter.

## Test plan
- Reset, then layer_start with rd_len=4, wr_len=4, rd_req held high and wr_vld held high -> bank0 read at addresses 0..3 and bank1 written at 0..3. layer_done fires exactly once, 2 cycles after the 4th accept, and src_bank goes to 1.
- Second layer, rd_len=3, wr_len=2 -> bank1 read at 0..2 and bank0 written at 0..1. ractmem1ena stays high through DRAIN. src_bank returns to 0.
- rd_req toggled 1,0,1,1 -> rd_vld follows one cycle later at the same positions, and addresses advance only on accepts.
- wr_len=2 with 3 wr_vld pulses -> exactly 2 write enables, wr_ovf=1 until the next layer_start.
- rd_len=0, wr_len=0 -> RUN one cycle, no enables asserted, layer_done 3 cycles after layer_start. A layer_start issued while busy is ignored.
- rst_n dropped mid-RUN -> all outputs 0 asynchronously, src_bank=0, no layer_done. With ACT_PP_HOST_LOAD_EN, host_wen=1, host_bank=1, host_addr=5 in IDLE -> wactmem1ena=1 and wactmem1addr=5 in the same cycle.
